// File: rtl/read_d_stream.sv
// Read-position table (symbol + search bound D(i)) with a span streamer
// that feeds the backward-search core over valid/ready.
module read_d_stream #(
  parameter int    SYM_W     = 2,
  parameter int    D_W       = 8,
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [SYM_W-1:0]  wr_sym,
  input  logic [D_W-1:0]    wr_d,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   start_len,
  input  logic              dir,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SYM_W-1:0]  out_sym,
  output logic [D_W-1:0]    out_d,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int ENT_W = SYM_W + D_W;
  localparam logic [ADDR_W-1:0] A_ONE = 1;
  localparam logic [ADDR_W:0]   R_ONE = 1;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  logic [ENT_W-1:0]  mem [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   remaining;
  logic              rev;
  logic [ADDR_W-1:0] rd_addr;
  logic [ENT_W-1:0]  rd_ent;
  logic              issue;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {wr_sym, wr_d};
  end

  assign rd_addr = base + idx;
  assign rd_ent  = mem[rd_addr];
  assign issue   = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base      <= '0;
      idx       <= '0;
      remaining <= '0;
      rev       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_sym   <= '0;
      out_d     <= '0;
      out_idx   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (start_len != '0) begin
              base      <= start_addr;
              rev       <= dir;
              idx       <= dir ? ADDR_W'(start_len - R_ONE) : '0;
              remaining <= start_len;
              busy      <= 1'b1;
              state     <= STREAM;
            end else begin
              done <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (issue) begin
            out_sym   <= rd_ent[ENT_W-1:D_W];
            out_d     <= rd_ent[D_W-1:0];
            out_idx   <= idx;
            out_valid <= 1'b1;
            out_last  <= (remaining == R_ONE);
            idx       <= rev ? idx - A_ONE : idx + A_ONE;
            remaining <= remaining - R_ONE;
            if (remaining == R_ONE) state <= FLUSH;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        FLUSH: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_read_d_stream.sv
// Directed and randomized bench for read_d_stream against an
// array model of the table and a queue of expected beats.
module tb_read_d_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_addr = '0;
    logic [1:0] wr_sym = '0;
    logic [7:0] wr_d = '0;
    logic       start = 1'b0;
    logic [7:0] start_addr = '0;
    logic [8:0] start_len = '0;
    logic       dir = 1'b0;
    logic       busy, done, out_valid, out_last;
    logic       out_ready = 1'b1;
    logic [1:0] out_sym;
    logic [7:0] out_d;
    logic [7:0] out_idx;

    int total = 0;
    int bad = 0;
    logic [9:0] model [256];
    int obs_d[$];

    read_d_stream dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_sym(wr_sym), .wr_d(wr_d),
        .start(start), .start_addr(start_addr), .start_len(start_len),
        .dir(dir), .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sym(out_sym), .out_d(out_d), .out_idx(out_idx),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [9:0] v);
        @(negedge clk);
        wr_en = 1'b1;
        wr_addr = a;
        wr_sym = v[9:8];
        wr_d = v[7:0];
        model[a] = v;
    endtask

    // wr_at >= 1 writes new data to beat wr_at's address on its issue edge
    task automatic do_stream(input logic [7:0] a, input int len,
                             input bit rev, input bit rnd, input int wr_at);
        logic [7:0] eidx[$];
        logic [7:0] e, addr, waddr;
        logic [9:0] nv;
        logic hp, hl;
        logic [1:0] hs;
        logic [7:0] hd, hi;
        int cyc;
        obs_d.delete();
        for (int k = 0; k < len; k++)
            eidx.push_back(8'(rev ? len - 1 - k : k));
        @(negedge clk);
        start = 1'b1;
        start_addr = a;
        start_len = 9'(len);
        dir = rev;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_on_accept", busy, len != 0);
        chk("valid_latency", out_valid, 0);
        if (len == 0) begin
            chk("zero_len_done", done, 1);
            @(negedge clk);
            chk("zero_len_done_clear", done, 0);
            chk("zero_len_no_valid", out_valid, 0);
            return;
        end
        cyc = 0;
        hp = 1'b0;
        waddr = '0;
        nv = '0;
        while (eidx.size() > 0 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            wr_en = 1'b0;
            start = 1'b0;
            if (cyc == 1) chk("first_valid", out_valid, 1);
            if (hp) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_sym", out_sym, hs);
                chk("stall_d", out_d, hd);
                chk("stall_idx", out_idx, hi);
                chk("stall_last", out_last, hl);
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rnd && busy && $urandom_range(0, 3) == 0) begin
                start = 1'b1;
                start_addr = 8'($urandom);
                start_len = 9'($urandom_range(0, 256));
                dir = 1'($urandom);
            end
            if (wr_at >= 1 && cyc == wr_at) begin
                waddr = a + 8'(rev ? len - 1 - wr_at : wr_at);
                nv = ~model[waddr];
                wr_en = 1'b1;
                wr_addr = waddr;
                wr_sym = nv[9:8];
                wr_d = nv[7:0];
            end
            if (out_valid && out_ready) begin
                e = eidx.pop_front();
                addr = a + e;
                chk("beat_idx", out_idx, e);
                chk("beat_sym", out_sym, model[addr][9:8]);
                chk("beat_d", out_d, model[addr][7:0]);
                chk("beat_last", out_last, eidx.size() == 0);
                obs_d.push_back(int'(out_d));
                hp = 1'b0;
            end else begin
                hp = out_valid;
                hs = out_sym;
                hd = out_d;
                hi = out_idx;
                hl = out_last;
            end
        end
        if (eidx.size() > 0) chk("stream_timeout", eidx.size(), 0);
        if (!rnd) chk("throughput_cycles", cyc, len);
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        chk("done_pulse", done, 1);
        chk("busy_fall", busy, 0);
        chk("valid_fall", out_valid, 0);
        @(negedge clk);
        chk("done_clear", done, 0);
        if (wr_at >= 1) model[waddr] = nv;
    endtask

    initial begin
        int dn;
        logic [7:0] kb;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_sym", out_sym, 0);
        chk("rst_d", out_d, 0);
        chk("rst_idx", out_idx, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 256; k++) begin
            kb = 8'(k);
            wr(kb, {kb[1:0], 8'(255 - k)});
        end
        @(negedge clk);
        wr_en = 1'b0;

        do_stream(8'd10, 4, 1'b0, 1'b0, -1);
        chk("fwd_count", obs_d.size(), 4);
        if (obs_d.size() == 4) begin
            chk("fwd_d0", obs_d[0], 245);
            chk("fwd_d3", obs_d[3], 242);
        end

        do_stream(8'd10, 4, 1'b1, 1'b0, -1);
        chk("rev_count", obs_d.size(), 4);
        if (obs_d.size() == 4) chk("rev_d0", obs_d[0], 242);

        do_stream(8'd254, 4, 1'b0, 1'b0, -1);
        chk("wrap_count", obs_d.size(), 4);
        if (obs_d.size() == 4) begin
            chk("wrap_d0", obs_d[0], 1);
            chk("wrap_d2", obs_d[2], 255);
        end

        do_stream(8'd40, 16, 1'b0, 1'b1, -1);
        chk("bp_count", obs_d.size(), 16);

        do_stream(8'd77, 0, 1'b0, 1'b0, -1);

        do_stream(8'd100, 6, 1'b0, 1'b0, 2);
        do_stream(8'd100, 6, 1'b1, 1'b0, -1);

        @(negedge clk);
        start = 1'b1;
        start_addr = 8'd20;
        start_len = 9'd20;
        dir = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_d", out_d, 0);
        chk("mid_rst_idx", out_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("mid_rst_no_done", dn, 0);

        for (int t = 0; t < 6; t++) begin
            repeat (3) wr(8'($urandom), 10'($urandom));
            @(negedge clk);
            wr_en = 1'b0;
            do_stream(8'($urandom), int'($urandom_range(1, 40)),
                      1'($urandom), 1'b1, -1);
        end

        do_stream(8'd0, 256, 1'b0, 1'b0, -1);
        chk("full_count", obs_d.size(), 256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
